// File: rtl/code24_pulse_decoder_if.sv
// Code handshake between a select producer and the pulse decoder.
// The producer (master) presents code/code_valid. The decoder (slave)
// answers with a combinational code_ready.
interface code24_pulse_decoder_if;
   logic       code_valid;
   logic [1:0] code;
   logic       code_ready;

   modport master (
      output code_valid,
      output code,
      input  code_ready
   );

   modport slave (
      input  code_valid,
      input  code,
      output code_ready
   );
endinterface

// File: rtl/code24_pulse_decoder.sv
// Sequential 2-to-4 decoder. A 2-bit code is taken over a valid/ready
// handshake, or generated by an internal scan index. The matching one-hot
// line is driven on F for HOLD_CYCLES cycles. An optional blanking gap of
// GAP_CYCLES cycles with F = 0 follows each drive.
module code24_pulse_decoder #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         scan_mode,
   code24_pulse_decoder_if.slave        hs,
   output logic [3:0]                   F,
   output logic [1:0]                   cur_code,
   output logic                         busy,
   output logic                         done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       code_q, code_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       idx_inc;
   logic             scan_q, scan_d;
   logic             done_d;
   logic [3:0]       f_d;
   logic             busy_d;

   assign idx_inc       = idx_q + 2'd1;
   assign hs.code_ready = en & ~scan_mode & (state_q == IDLE);

   // Next-state logic. The scan/manual choice is latched into scan_q when
   // leaving IDLE, so a change on scan_mode mid-operation is ignored.
   // An en drop in DRIVE or GAP takes priority over completing the drive,
   // so an aborted drive never raises done.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      idx_d   = idx_q;
      scan_d  = scan_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               if (scan_mode) begin
                  state_d = DRIVE;
                  code_d  = idx_q;
                  cnt_d   = HOLD_LOAD;
                  scan_d  = 1'b1;
               end else if (hs.code_valid) begin
                  state_d = DRIVE;
                  code_d  = hs.code;
                  cnt_d   = HOLD_LOAD;
                  scan_d  = 1'b0;
               end
            end
         end
         DRIVE: begin
            if (!en) begin
               state_d = IDLE;
               idx_d   = 2'd0;
            end else if (cnt_q == '0) begin
               done_d = 1'b1;
               if (scan_q) begin
                  idx_d = idx_inc;
               end
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end else if (scan_q) begin
                  state_d = DRIVE;
                  code_d  = idx_inc;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (!en) begin
               state_d = IDLE;
               idx_d   = 2'd0;
            end else if (cnt_q == '0) begin
               if (scan_q) begin
                  state_d = DRIVE;
                  code_d  = idx_q;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state. This
   // keeps F and busy registered while still aligning them with the state.
   always_comb begin
      f_d    = 4'b0000;
      busy_d = (state_d != IDLE);
      if (state_d == DRIVE) begin
         f_d = 4'b0001 << code_d;
      end
   end

   // State and output registers, cleared asynchronously on rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         code_q  <= 2'd0;
         idx_q   <= 2'd0;
         scan_q  <= 1'b0;
         F       <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         scan_q  <= scan_d;
         F       <= f_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   assign cur_code = code_q;

endmodule

// File: tb/tb_code24_pulse_decoder.sv
// Directed bench for code24_pulse_decoder. dut0 runs with HOLD=3, GAP=1.
// dut1 runs with HOLD=3, GAP=0 for gapless scanning.
module tb_code24_pulse_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en0, scan0, en1, scan1;
   logic [3:0] f0, f1;
   logic [1:0] cc0, cc1;
   logic       busy0, busy1, done0, done1;

   int vectors     = 0;
   int miscompares = 0;

   code24_pulse_decoder_if hs0 ();
   code24_pulse_decoder_if hs1 ();

   code24_pulse_decoder #(.HOLD_CYCLES(3), .GAP_CYCLES(1), .CNT_W(8)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en0),
      .scan_mode (scan0),
      .hs        (hs0),
      .F         (f0),
      .cur_code  (cc0),
      .busy      (busy0),
      .done      (done0)
   );

   code24_pulse_decoder #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .CNT_W(8)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en1),
      .scan_mode (scan1),
      .hs        (hs1),
      .F         (f1),
      .cur_code  (cc1),
      .busy      (busy1),
      .done      (done1)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to 1 unit after the next rising edge; inputs change here
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] scan_f    [19] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                  4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0,
                                  4'h1, 4'h1, 4'h1};
   logic [3:0] nogap_f   [15] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4,
                                  4'h4, 4'h8, 4'h8, 4'h8, 4'h1, 4'h1, 4'h1};
   logic       nogap_d   [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      rst_n = 1'b0;
      en0 = 1'b0; scan0 = 1'b0; en1 = 1'b0; scan1 = 1'b0;
      hs0.code_valid = 1'b0; hs0.code = 2'd0;
      hs1.code_valid = 1'b0; hs1.code = 2'd0;

      // Reset state
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("reset_F",     8'(f0),          8'h00);
      checkOutput("reset_busy",  8'(busy0),       8'h00);
      checkOutput("reset_done",  8'(done0),       8'h00);
      checkOutput("reset_code",  8'(cc0),         8'h00);
      checkOutput("reset_ready", 8'(hs0.code_ready), 8'h00);
      checkOutput("reset_F1",    8'(f1),          8'h00);

      // Manual accept of code 2
      en0 = 1'b1;
      hs0.code = 2'd2;
      hs0.code_valid = 1'b1;
      #1;
      checkOutput("m2_ready_idle", 8'(hs0.code_ready), 8'h01);
      applyStimulus();
      hs0.code_valid = 1'b0;
      checkOutput("m2_F_c1",    8'(f0),    8'h04);
      checkOutput("m2_busy_c1", 8'(busy0), 8'h01);
      checkOutput("m2_code",    8'(cc0),   8'h02);
      checkOutput("m2_ready_busy", 8'(hs0.code_ready), 8'h00);
      applyStimulus();
      checkOutput("m2_F_c2",    8'(f0),    8'h04);
      applyStimulus();
      checkOutput("m2_F_c3",    8'(f0),    8'h04);
      checkOutput("m2_done_c3", 8'(done0), 8'h00);
      applyStimulus();
      checkOutput("m2_F_gap",    8'(f0),    8'h00);
      checkOutput("m2_done_gap", 8'(done0), 8'h01);
      checkOutput("m2_busy_gap", 8'(busy0), 8'h01);
      applyStimulus();
      checkOutput("m2_done_idle",  8'(done0), 8'h00);
      checkOutput("m2_busy_idle",  8'(busy0), 8'h00);
      checkOutput("m2_ready_back", 8'(hs0.code_ready), 8'h01);

      // All codes back to back, each accepted on the first ready cycle
      for (int c = 0; c < 4; c++) begin
         hs0.code = 2'(c);
         hs0.code_valid = 1'b1;
         applyStimulus();
         hs0.code_valid = 1'b0;
         for (int h = 0; h < 3; h++) begin
            checkOutput($sformatf("all_F_c%0d_h%0d", c, h), 8'(f0), 8'(onehot[c]));
            checkOutput($sformatf("all_done_c%0d_h%0d", c, h), 8'(done0), 8'h00);
            if (h < 2) applyStimulus();
         end
         applyStimulus();
         checkOutput($sformatf("all_Fgap_c%0d", c), 8'(f0), 8'h00);
         checkOutput($sformatf("all_done_c%0d", c), 8'(done0), 8'h01);
         applyStimulus();
         checkOutput($sformatf("all_ready_c%0d", c), 8'(hs0.code_ready), 8'h01);
      end

      // Asynchronous reset in the middle of a drive of code 3
      hs0.code = 2'd3;
      hs0.code_valid = 1'b1;
      applyStimulus();
      hs0.code_valid = 1'b0;
      applyStimulus();
      checkOutput("ar_F_pre", 8'(f0), 8'h08);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_F",    8'(f0),    8'h00);
      checkOutput("ar_busy", 8'(busy0), 8'h00);
      checkOutput("ar_done", 8'(done0), 8'h00);
      checkOutput("ar_code", 8'(cc0),   8'h00);
      rst_n = 1'b1;

      // Scan mode with a busy code_valid that must be ignored
      en0 = 1'b0;
      applyStimulus();
      scan0 = 1'b1;
      en0 = 1'b1;
      hs0.code = 2'd3;
      hs0.code_valid = 1'b1;
      #1;
      checkOutput("scan_ready_idle", 8'(hs0.code_ready), 8'h00);
      for (int i = 0; i < 19; i++) begin
         applyStimulus();
         checkOutput($sformatf("scan_F_%0d", i),     8'(f0),    8'(scan_f[i]));
         checkOutput($sformatf("scan_done_%0d", i),  8'(done0), 8'(scan_f[i] == 4'h0));
         checkOutput($sformatf("scan_ready_%0d", i), 8'(hs0.code_ready), 8'h00);
      end
      hs0.code_valid = 1'b0;

      // Abort on the final drive cycle of code 0: abort beats done
      en0 = 1'b0;
      applyStimulus();
      checkOutput("abs_F",    8'(f0),    8'h00);
      checkOutput("abs_busy", 8'(busy0), 8'h00);
      checkOutput("abs_done", 8'(done0), 8'h00);

      // Abort in the 2nd drive cycle of manual code 3
      scan0 = 1'b0;
      en0 = 1'b1;
      hs0.code = 2'd3;
      hs0.code_valid = 1'b1;
      applyStimulus();
      hs0.code_valid = 1'b0;
      applyStimulus();
      checkOutput("ab3_F_pre", 8'(f0), 8'h08);
      en0 = 1'b0;
      scan0 = 1'b1;
      applyStimulus();
      checkOutput("ab3_F",    8'(f0),    8'h00);
      checkOutput("ab3_busy", 8'(busy0), 8'h00);
      checkOutput("ab3_done", 8'(done0), 8'h00);
      checkOutput("ab3_code", 8'(cc0),   8'h03);
      applyStimulus();
      checkOutput("ab3_done2", 8'(done0), 8'h00);
      en0 = 1'b1;
      applyStimulus();
      checkOutput("ab3_restart_F",    8'(f0),  8'h01);
      checkOutput("ab3_restart_code", 8'(cc0), 8'h00);
      en0 = 1'b0;

      // Gapless scanning on dut1
      scan1 = 1'b1;
      en1 = 1'b1;
      for (int i = 0; i < 15; i++) begin
         applyStimulus();
         checkOutput($sformatf("ng_F_%0d", i),    8'(f1),    8'(nogap_f[i]));
         checkOutput($sformatf("ng_done_%0d", i), 8'(done1), 8'(nogap_d[i]));
         checkOutput($sformatf("ng_busy_%0d", i), 8'(busy1), 8'h01);
      end
      en1 = 1'b0;
      applyStimulus();
      checkOutput("ng_abort_F", 8'(f1), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
